// File: rtl/skinny_sbox8_dom1_serial_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// skinny_sbox8_dom1_serial_ctrl_pkg
//   Shared constants and FSM encoding for the serial SubCells sequencer that
//   drives one 2-share (DOM order 1) SKINNY 8-bit sbox.
//   Contents:
//     SKINNY_NBYTES   bytes per state share
//     SBOX8_DOM1_RW   randomness bits consumed per sbox evaluation
//     SBOX8_DOM1_LAT  edges from byte issue to capture of the sbox output
//     IDLE/FETCH/HOLD/DRAIN/DONE  state encodings, wrapped in fsm_state_e
// ---------------------------------------------------------------------------
package skinny_sbox8_dom1_serial_ctrl_pkg;

  localparam int SKINNY_NBYTES  = 16;
  localparam int SBOX8_DOM1_RW  = 25;
  localparam int SBOX8_DOM1_LAT = 2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] HOLD  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = IDLE,
    ST_FETCH = FETCH,
    ST_HOLD  = HOLD,
    ST_DRAIN = DRAIN,
    ST_DONE  = DONE
  } fsm_state_e;

endpackage

// File: rtl/skinny_sbox8_dom1_serial_ctrl_shreg.sv
// ---------------------------------------------------------------------------
// skinny_share_shreg
//   One state share held as a byte-rotating shift register. A load replaces
//   the whole share; a shift drops the low byte and inserts a new byte at the
//   top, so after NBYTES shifts byte k of the input has been replaced by the
//   k-th inserted byte in the same position.
//   Ports:
//     clk     clock
//     rst_n   synchronous active-low reset (clears the register)
//     load_i  load data_i (has priority over shift_i)
//     data_i  full share to load
//     shift_i shift right by one byte, byte_i enters at the top
//     byte_i  byte inserted on shift
//     q_o     current register contents
// ---------------------------------------------------------------------------
module skinny_share_shreg
  import skinny_sbox8_dom1_serial_ctrl_pkg::*;
#(
  parameter int NBYTES = SKINNY_NBYTES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [8*NBYTES-1:0]   data_i,
  input  logic                  shift_i,
  input  logic [7:0]            byte_i,
  output logic [8*NBYTES-1:0]   q_o
);

  localparam int W = 8 * NBYTES;

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= data_i;
    end else if (shift_i) begin
      q_q <= {byte_i, q_q[W-1:8]};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/skinny_sbox8_dom1_serial_ctrl.sv
// ---------------------------------------------------------------------------
// skinny_sbox8_dom1_serial_ctrl
//   Serial SubCells sequencer for a 2-share SKINNY-128 state. Issues one
//   byte pair (plus a fresh randomness word) to an external masked sbox every
//   two cycles at best, keeps the sbox inputs frozen for the two-cycle
//   evaluation window, and shifts the sbox output shares back into the
//   rotating state. done pulses once all bytes have been substituted.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     start                 1-cycle pulse, accepted only when idle
//     st0_i / st1_i         input state shares
//     rnd, rnd_valid        upstream randomness word and its valid flag
//     rnd_ready             word consumed this cycle
//     sb_si0/sb_si1/sb_r    registered sbox input shares and refresh mask
//     sb_bo0/sb_bo1         sbox output shares
//     st0_o / st1_o         substituted state shares, valid when done=1
//     busy                  operation in progress
//     done                  1-cycle completion pulse
// ---------------------------------------------------------------------------
module skinny_sbox8_dom1_serial_ctrl
  import skinny_sbox8_dom1_serial_ctrl_pkg::*;
#(
  parameter int NBYTES = SKINNY_NBYTES,
  parameter int RW     = SBOX8_DOM1_RW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   st0_i,
  input  logic [8*NBYTES-1:0]   st1_i,
  input  logic [RW-1:0]         rnd,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  output logic [7:0]            sb_si0,
  output logic [7:0]            sb_si1,
  output logic [RW-1:0]         sb_r,
  input  logic [7:0]            sb_bo0,
  input  logic [7:0]            sb_bo1,
  output logic [8*NBYTES-1:0]   st0_o,
  output logic [8*NBYTES-1:0]   st1_o,
  output logic                  busy,
  output logic                  done
);

  localparam int W   = 8 * NBYTES;
  localparam int CW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int LAT = SBOX8_DOM1_LAT;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  fsm_state_e            state_q;
  logic [CW-1:0]         cnt_q;
  logic [LAT-1:0]        cap_pipe_q;
  logic [1:0][7:0]       sb_si_q;
  logic [RW-1:0]         sb_r_q;
  logic [1:0][W-1:0]     st_o_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  issue;
  logic                  capture;
  logic                  load;
  logic [1:0][W-1:0]     st_in;
  logic [1:0][7:0]       bo_in;
  logic [1:0][W-1:0]     sh_q;
  logic [1:0][7:0]       iss_byte;

  // The ready flag is the handshake itself: it is only raised when a word
  // is actually present and the FSM is waiting for one.
  assign rnd_ready = (state_q == ST_FETCH) && rnd_valid;
  assign issue     = rnd_ready;
  assign load      = (state_q == ST_IDLE) && start;

  // Capture is a free-running delayed copy of the issue pulse, so a stall
  // in FETCH never postpones the write-back of an already issued byte.
  assign capture   = cap_pipe_q[LAT-1];

  assign st_in = {st1_i, st0_i};
  assign bo_in = {sb_bo1, sb_bo0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_share
      skinny_share_shreg #(
        .NBYTES (NBYTES)
      ) u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .data_i  (st_in[gi]),
        .shift_i (capture),
        .byte_i  (bo_in[gi]),
        .q_o     (sh_q[gi])
      );

      // When the next issue coincides with the previous byte's capture the
      // register has not shifted yet, so the next byte still sits one slot up.
      assign iss_byte[gi] = capture ? sh_q[gi][15:8] : sh_q[gi][7:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cap_pipe_q <= '0;
      sb_si_q    <= '0;
      sb_r_q     <= '0;
      st_o_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cap_pipe_q <= {cap_pipe_q[LAT-2:0], issue};
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (issue) begin
            sb_si_q <= iss_byte;
            sb_r_q  <= rnd;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == LAST_BYTE) begin
            state_q <= ST_DRAIN;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          // The last byte's capture lands on the edge that leaves this state.
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          st_o_q  <= sh_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sb_si0 = sb_si_q[0];
  assign sb_si1 = sb_si_q[1];
  assign sb_r   = sb_r_q;
  assign st0_o  = st_o_q[0];
  assign st1_o  = st_o_q[1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
